instx_mem_loader: RTL and testbench
===================================

// Module: instx_mem_loader
// PURPOSE
//  Boot-time writer for the 128x32 instruction memory.
//  Receives a byte stream over a valid/ready handshake and packs each 4 bytes into a 32-bit word.
//  Writes words to consecutive IM addresses starting at 0.
//  Holds the CPU (CpuHold) until the requested word count has been written.
//  Sits between the external boot link and the IM write port; the fetch path reads the same array.
// PARAMETERS
//  ADDR_W   7     IM word-address width (depth = 2**ADDR_W = 128)
//  DATA_W   32    instruction width; must equal 4*8
//  TIMEOUT  1024  idle cycles allowed in RECV before Error
// PORTS
//  Clock1     in   1       system clock, rising edge
//  Reset      in   1       asynchronous, active-low
//  Start      in   1       1-cycle pulse: begin a load
//  WordCount  in   ADDR_W+1  words to load, sampled on Start; 0 or >128 treated as 128
//  ByteIn     in   8       stream byte
//  ByteValid  in   1       ByteIn valid
//  ByteReady  out  1       loader accepts byte this cycle
//  MemWrEn    out  1       IM write strobe, one cycle per word
//  MemWrAddr  out  ADDR_W  IM word address
//  MemWrData  out  DATA_W  IM word data
//  CpuHold    out  1       1 = CPU/PC held in reset
//  Done       out  1       load completed
//  Error      out  1       load aborted by timeout
// BEHAVIOUR
//  Reset values (async on !Reset):
//   - state=IDLE; ByteReady=0; MemWrEn=0; MemWrAddr=0; MemWrData=0
//   - CpuHold=1; Done=0; Error=0
//   - byte/word/timeout counters = 0
//  FSM states: IDLE, RECV, WRITE, DONE, ERROR.
//  IDLE:
//   - Start -> RECV; latch count (0 or >128 -> 128); word index=0; byte index=0.
//  RECV:
//   - ByteReady=1. A byte is accepted when ByteValid&&ByteReady at a rising edge.
//   - Byte order is big-endian: byte0 -> [31:24], byte1 -> [23:16], byte2 -> [15:8], byte3 -> [7:0].
//   - The 4th accepted byte moves to WRITE on the next edge.
//  WRITE (exactly 1 cycle):
//   - ByteReady=0; MemWrEn=1; MemWrAddr=word index; MemWrData=packed word.
//   - Next: word index+1; if it equals count -> DONE, else -> RECV with byte index=0.
//  Latency: 4th byte accepted at edge n -> MemWrEn high during cycle n..n+1.
//   - Last word: Done=1 and CpuHold=0 from edge n+2.
//  DONE:
//   - Done=1; CpuHold=0; ByteReady=0. Stays until Start.
//   - Start -> RECV: Done=0, CpuHold=1, count relatched.
//  ERROR:
//   - Entered when TIMEOUT consecutive RECV cycles pass with no accepted byte (counter clears on each accept).
//   - Error=1; CpuHold=1; ByteReady=0. Start -> RECV with Error=0.
//   - Any partial word is discarded.
//  Start while in RECV/WRITE is ignored.
//  ByteValid outside RECV is ignored; no byte is consumed.
//  Address wrap: never occurs; a count of 128 ends at address 127.
//  Reset mid-load: FSM returns to IDLE with CpuHold=1. Words already written stay in IM (no clear).
// TESTING
//  1. Reset, Start with WordCount=1, bytes 12 34 56 78 back-to-back
//     -> one MemWrEn, addr 0, data 32'h12345678; Done=1, CpuHold=0 two edges after byte 4.
//  2. WordCount=3, stream with ByteValid gaps
//     -> writes to addr 0,1,2 in order, data correct; ByteReady=0 on each WRITE cycle.
//  3. WordCount=0
//     -> 128 writes, addr 0..127, last at 127; Done=1; no write to addr 0 after 127.
//  4. Start, 2 bytes, then ByteValid=0 for 1024 cycles
//     -> Error=1, CpuHold=1, no MemWrEn; second Start plus 4 bytes -> write at addr 0, Error=0.
//  5. Reset low mid-word (after 2 bytes of word 1)
//     -> all outputs at reset values immediately; word 0 remains in IM model.
//  6. Start pulsed during RECV, and ByteValid held in IDLE/DONE
//     -> no state change, no byte consumed, count unchanged.

Source files
------------

// File: rtl/instx_mem_loader_if.sv
// Boot-link byte stream and IM write-port bundle for the instruction memory loader.
// The slave side is the loader; the master side is whoever drives the boot link and watches the IM port.
interface instx_mem_loader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              Start;
  logic [ADDR_W:0]   WordCount;
  logic [7:0]        ByteIn;
  logic              ByteValid;
  logic              ByteReady;
  logic              MemWrEn;
  logic [ADDR_W-1:0] MemWrAddr;
  logic [DATA_W-1:0] MemWrData;
  logic              CpuHold;
  logic              Done;
  logic              Error;

  modport slave (
    input  Start, WordCount, ByteIn, ByteValid,
    output ByteReady, MemWrEn, MemWrAddr, MemWrData, CpuHold, Done, Error
  );

  modport master (
    output Start, WordCount, ByteIn, ByteValid,
    input  ByteReady, MemWrEn, MemWrAddr, MemWrData, CpuHold, Done, Error
  );
endinterface

// File: rtl/instx_mem_loader.sv
// Boot-time loader: packs a big-endian byte stream into 32-bit words and writes them to IM from address 0.
// One WRITE cycle per word (ByteReady low); Done/CpuHold release one cycle after the final write completes.
module instx_mem_loader #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              Clock1,
  input  logic              Reset,
  instx_mem_loader_if.slave ld
);
  localparam int              TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_word_idx;
  logic [ADDR_W:0]   w_idx_inc;
  logic [ADDR_W:0]   w_count_in;
  logic [1:0]        r_byte_idx;
  logic [DATA_W-1:0] r_word;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_done;
  logic              w_accept;
  logic              w_start_ok;
  logic              w_tmo_hit;

  assign w_accept   = (r_state == S_RECV) && ld.ByteValid;
  assign w_start_ok = ld.Start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  // Zero and anything past the array depth both mean "fill the whole IM".
  assign w_count_in = ((ld.WordCount == '0) || (ld.WordCount > DEPTH)) ? DEPTH : ld.WordCount;
  assign w_idx_inc  = r_word_idx + {{ADDR_W{1'b0}}, 1'b1};
  assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (ld.Start) w_next = S_RECV;
      end
      S_RECV: begin
        if (w_accept && (r_byte_idx == 2'd3)) w_next = S_WRITE;
        else if (!w_accept && w_tmo_hit)      w_next = S_ERROR;
      end
      S_WRITE: begin
        if (w_idx_inc == r_count) w_next = S_DONE;
        else                      w_next = S_RECV;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock1 or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_tmo      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      // Registered off the DONE state so the CPU is released only after the last write has settled.
      r_done  <= (r_state == S_DONE) && !ld.Start;
      if (w_start_ok) begin
        r_count    <= w_count_in;
        r_word_idx <= '0;
        r_byte_idx <= '0;
        r_tmo      <= '0;
      end else if (r_state == S_RECV) begin
        if (w_accept) begin
          r_word     <= {r_word[DATA_W-9:0], ld.ByteIn};
          r_byte_idx <= r_byte_idx + 2'd1;
          r_tmo      <= '0;
        end else begin
          r_tmo <= r_tmo + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end else if (r_state == S_WRITE) begin
        r_word_idx <= w_idx_inc;
        r_byte_idx <= '0;
        r_tmo      <= '0;
      end
    end
  end

  assign ld.ByteReady = (r_state == S_RECV);
  assign ld.MemWrEn   = (r_state == S_WRITE);
  assign ld.MemWrAddr = r_word_idx[ADDR_W-1:0];
  assign ld.MemWrData = r_word;
  assign ld.Done      = r_done;
  assign ld.CpuHold   = !r_done;
  assign ld.Error     = (r_state == S_ERROR);
endmodule

// File: tb/tb_instx_mem_loader.sv
// Directed bench for instx_mem_loader: inputs change 1 time unit after the rising edge,
// IM writes are logged on the falling edge into a word-array model.
module tb_instx_mem_loader;
  logic Clock1 = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  always #5 Clock1 = ~Clock1;

  instx_mem_loader_if bus ();
  instx_mem_loader dut (.Clock1(Clock1), .Reset(Reset), .ld(bus));

  logic [31:0] im [128];
  logic [6:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          rdy_in_write = 0;

  always @(negedge Clock1) begin
    if (bus.MemWrEn === 1'b1) begin
      im[bus.MemWrAddr] = bus.MemWrData;
      wr_addr_q.push_back(bus.MemWrAddr);
      wr_data_q.push_back(bus.MemWrData);
      if (bus.ByteReady !== 1'b0) rdy_in_write++;
    end
  end

  task automatic tick();
    @(posedge Clock1);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rdy_in_write = 0;
  endtask

  task automatic pulse_start(input logic [7:0] cnt);
    bus.WordCount = cnt;
    bus.Start     = 1'b1;
    tick();
    bus.Start     = 1'b0;
  endtask

  // Presents one byte and returns just after the edge that accepts it; ByteValid is left high.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit rdy;
    bus.ByteIn    = b;
    bus.ByteValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rdy = bus.ByteReady;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, output bit ok);
    bit b_ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8], b_ok);
      if (!b_ok) ok = 1'b0;
      if (gap > 0 && k < 3) begin
        bus.ByteValid = 1'b0;
        repeat (gap) tick();
      end
    end
    bus.ByteValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.Start = 1'b0; bus.WordCount = '0; bus.ByteIn = '0; bus.ByteValid = 1'b0;
    #3;
    checks++;
    if ({bus.ByteReady, bus.MemWrEn, bus.MemWrAddr, bus.MemWrData, bus.CpuHold, bus.Done, bus.Error}
        !== {1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b wen=%b addr=%0d data=%h hold=%b done=%b err=%b, required 0 0 0 00000000 1 0 0",
               bus.ByteReady, bus.MemWrEn, bus.MemWrAddr, bus.MemWrData, bus.CpuHold, bus.Done, bus.Error);
    end
    repeat (2) tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    clear_log();
    pulse_start(8'd1);
    send_word(32'h12345678, 0, ok);
    checks++;
    if (!ok || bus.MemWrEn !== 1'b1 || bus.MemWrAddr !== 7'd0 || bus.MemWrData !== 32'h12345678) begin
      errors++;
      $display("FAIL single_write: ok=%b wen=%b addr=%0d data=%h, required 1 1 0 12345678", ok, bus.MemWrEn, bus.MemWrAddr, bus.MemWrData);
    end
    tick();
    checks++;
    if ({bus.MemWrEn, bus.Done, bus.CpuHold} !== 3'b001) begin
      errors++;
      $display("FAIL single_edge1: wen/done/hold=%b, required 001", {bus.MemWrEn, bus.Done, bus.CpuHold});
    end
    tick();
    checks++;
    if ({bus.Done, bus.CpuHold} !== 2'b10) begin
      errors++;
      $display("FAIL single_done: done/hold=%b, required 10", {bus.Done, bus.CpuHold});
    end
    checks++;
    if (wr_addr_q.size() != 1) begin
      errors++;
      $display("FAIL single_count: writes=%0d, required 1", wr_addr_q.size());
    end
  endtask

  task automatic test_gaps();
    bit ok, all_ok;
    logic [31:0] w [3] = '{32'hA1B2C3D4, 32'h00FF00FF, 32'hCAFEF00D};
    clear_log();
    all_ok = 1'b1;
    pulse_start(8'd3);
    checks++;
    if ({bus.Done, bus.CpuHold, bus.ByteReady} !== 3'b011) begin
      errors++;
      $display("FAIL restart_from_done: done/hold/rdy=%b, required 011", {bus.Done, bus.CpuHold, bus.ByteReady});
    end
    for (int i = 0; i < 3; i++) begin
      send_word(w[i], 2, ok);
      if (!ok) all_ok = 1'b0;
    end
    repeat (2) tick();
    checks++;
    if (!all_ok || wr_addr_q.size() != 3) begin
      errors++;
      $display("FAIL gaps_count: ok=%b writes=%0d, required 1 3", all_ok, wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr_q[i] !== 7'(i) || wr_data_q[i] !== w[i]) begin
          errors++;
          $display("FAIL gaps_word%0d: addr=%0d data=%h, required %0d %h", i, wr_addr_q[i], wr_data_q[i], i, w[i]);
        end
      end
    end
    checks++;
    if (rdy_in_write != 0 || bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL gaps_rdy_done: rdy_in_write=%0d done=%b, required 0 1", rdy_in_write, bus.Done);
    end
  endtask

  task automatic test_full();
    bit ok, all_ok;
    int bad;
    logic [31:0] w;
    clear_log();
    all_ok = 1'b1;
    pulse_start(8'd0);
    for (int i = 0; i < 128; i++) begin
      w = {8'(i), 8'(i) ^ 8'hFF, 8'(i + 1), 8'hC3};
      send_word(w, 0, ok);
      if (!ok) all_ok = 1'b0;
    end
    repeat (2) tick();
    checks++;
    if (!all_ok || bus.Done !== 1'b1 || wr_addr_q.size() != 128) begin
      errors++;
      $display("FAIL full_count: ok=%b done=%b writes=%0d, required 1 1 128", all_ok, bus.Done, wr_addr_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 128; i++) begin
        w = {8'(i), 8'(i) ^ 8'hFF, 8'(i + 1), 8'hC3};
        if (wr_addr_q[i] !== 7'(i) || wr_data_q[i] !== w) bad++;
      end
      checks++;
      if (bad != 0 || wr_addr_q[127] !== 7'd127) begin
        errors++;
        $display("FAIL full_contents: bad_words=%0d last_addr=%0d, required 0 127", bad, wr_addr_q[127]);
      end
    end
    repeat (5) tick();
    checks++;
    if (wr_addr_q.size() != 128 || bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL full_no_extra: writes=%0d done=%b, required 128 1", wr_addr_q.size(), bus.Done);
    end
  endtask

  task automatic test_timeout();
    bit ok1, ok2;
    clear_log();
    pulse_start(8'd1);
    send_byte(8'h11, ok1);
    send_byte(8'h22, ok2);
    bus.ByteValid = 1'b0;
    repeat (1023) tick();
    checks++;
    if (!ok1 || !ok2 || bus.Error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: ok=%b%b err=%b, required 11 0", ok1, ok2, bus.Error);
    end
    tick();
    checks++;
    if ({bus.Error, bus.CpuHold, bus.ByteReady} !== 3'b110 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_error: err/hold/rdy=%b writes=%0d, required 110 0", {bus.Error, bus.CpuHold, bus.ByteReady}, wr_addr_q.size());
    end
    pulse_start(8'd1);
    checks++;
    if (bus.Error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err=%b, required 0", bus.Error);
    end
    send_word(32'hDEADBEEF, 0, ok1);
    repeat (2) tick();
    checks++;
    if (!ok1 || wr_addr_q.size() != 1 || wr_addr_q[0] !== 7'd0 || wr_data_q[0] !== 32'hDEADBEEF || bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover: ok=%b writes=%0d addr=%0d data=%h done=%b, required 1 1 0 deadbeef 1",
               ok1, wr_addr_q.size(), wr_addr_q[0], wr_data_q[0], bus.Done);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    pulse_start(8'd2);
    send_word(32'h0BADC0DE, 0, ok);
    tick();
    send_byte(8'h55, ok);
    send_byte(8'h66, ok);
    bus.ByteValid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({bus.ByteReady, bus.MemWrEn, bus.MemWrAddr, bus.MemWrData, bus.CpuHold, bus.Done, bus.Error}
        !== {1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b wen=%b addr=%0d data=%h hold=%b done=%b err=%b, required 0 0 0 00000000 1 0 0",
               bus.ByteReady, bus.MemWrEn, bus.MemWrAddr, bus.MemWrData, bus.CpuHold, bus.Done, bus.Error);
    end
    checks++;
    if (wr_addr_q.size() != 1 || im[0] !== 32'h0BADC0DE) begin
      errors++;
      $display("FAIL midreset_im: writes=%0d im0=%h, required 1 0badc0de", wr_addr_q.size(), im[0]);
    end
    #3 Reset = 1'b1;
    tick();
    // ByteValid held while idle must not be consumed.
    bus.ByteIn    = 8'hEE;
    bus.ByteValid = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus.ByteReady !== 1'b0 || bus.CpuHold !== 1'b1 || wr_addr_q.size() != 1) begin
      errors++;
      $display("FAIL idle_hold: rdy=%b hold=%b writes=%0d, required 0 1 1", bus.ByteReady, bus.CpuHold, wr_addr_q.size());
    end
    bus.ByteValid = 1'b0;
  endtask

  task automatic test_ignore();
    bit ok1, ok2, ok3;
    clear_log();
    pulse_start(8'd2);
    send_byte(8'hAB, ok1);
    send_byte(8'hCD, ok1);
    bus.ByteValid = 1'b0;
    pulse_start(8'd1);
    send_byte(8'hEF, ok2);
    send_byte(8'h01, ok2);
    bus.ByteValid = 1'b0;
    repeat (2) tick();
    checks++;
    if (!ok1 || !ok2 || wr_addr_q.size() != 1 || wr_data_q[0] !== 32'hABCDEF01 || bus.Done !== 1'b0 || bus.ByteReady !== 1'b1) begin
      errors++;
      $display("FAIL start_in_recv: ok=%b%b writes=%0d data=%h done=%b rdy=%b, required 11 1 abcdef01 0 1",
               ok1, ok2, wr_addr_q.size(), wr_data_q[0], bus.Done, bus.ByteReady);
    end
    send_word(32'h13572468, 0, ok3);
    repeat (2) tick();
    bus.ByteIn    = 8'h99;
    bus.ByteValid = 1'b1;
    repeat (5) tick();
    checks++;
    if (!ok3 || wr_addr_q.size() != 2 || wr_addr_q[1] !== 7'd1 || bus.Done !== 1'b1 || bus.ByteReady !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: ok=%b writes=%0d addr1=%0d done=%b rdy=%b, required 1 2 1 1 0",
               ok3, wr_addr_q.size(), wr_addr_q[1], bus.Done, bus.ByteReady);
    end
    bus.ByteValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_full();
    test_timeout();
    test_reset_mid();
    test_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
